// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit frame sequencer.
// Holds the FSM state encoding, the line-mux select codes and the
// state-to-select decode used by uart_tx_ctrl.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  typedef logic [1:0] mux_sel_t;

  localparam mux_sel_t MUX_START = 2'd0;  // line driven low for the start bit
  localparam mux_sel_t MUX_STOP  = 2'd1;  // line driven high (idle and stop bits)
  localparam mux_sel_t MUX_SER   = 2'd2;  // line follows the serializer bit
  localparam mux_sel_t MUX_PAR   = 2'd3;  // line carries the latched parity bit

  // Map a frame state to the line source it selects.
  function automatic mux_sel_t mux_sel(input state_t s);
    case (s)
      START:   return MUX_START;
      DATA:    return MUX_SER;
      PARITY:  return MUX_PAR;
      default: return MUX_STOP;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity generator: XOR of the payload folded with the
// parity type (0 = even, 1 = odd). The result is registered by the parent.
module uart_tx_parity_calc (
  input  logic [7:0] data,
  input  logic       par_typ,
  output logic       par_bit
);

  // Reduction XOR gives 1 for an odd count of ones; odd parity inverts it.
  assign par_bit = (^data) ^ par_typ;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer. Sits between the host interface and the
// serializer: accepts one byte per DATA_VALID pulse, enables the serializer,
// and drives the registered serial line with start, data, optional parity
// and stop bits. Reports busy for the whole frame.
// Optional feature: define UART_TX_PARITY_EN to add the PAR_EN/PAR_TYP ports,
// the parity latch and the PARITY state.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
`ifdef UART_TX_PARITY_EN
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
`endif
  input  logic                  ser_data,
  input  logic                  ser_done,
  output logic                  ser_en,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam logic [1:0] STOP_LAST = 2'(STOP_BITS - 1);

  state_t     state_q, state_d;
  logic [1:0] stop_cnt_q, stop_cnt_d;
  logic       ser_en_q, ser_en_d;
  logic       busy_q, busy_d;
  logic       tx_out_q, tx_out_d;
  logic       last_stop;
  logic       accept;

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_bit_q, par_bit_d;
  logic par_calc;

  uart_tx_parity_calc u_parity_calc (
    .data    (P_DATA),
    .par_typ (PAR_TYP),
    .par_bit (par_calc)
  );
`endif

  assign last_stop = (stop_cnt_q == STOP_LAST);
  // A request is taken only from IDLE or on the final stop cycle; no queueing.
  assign accept    = DATA_VALID && ((state_q == IDLE) || ((state_q == STOP) && last_stop));

  // Next-state, stop counter, registered-output and parity-latch logic.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d    = state_q;
    stop_cnt_d = stop_cnt_q;
    case (state_q)
      IDLE:   if (DATA_VALID) state_d = START;
      START:  state_d = DATA;
      DATA: begin
        if (ser_done) begin
`ifdef UART_TX_PARITY_EN
          state_d = par_en_q ? PARITY : STOP;
`else
          state_d = STOP;
`endif
        end
      end
      PARITY: state_d = STOP;
      STOP: begin
        if (last_stop) begin
          stop_cnt_d = 2'd0;
          state_d    = DATA_VALID ? START : IDLE;
        end else begin
          stop_cnt_d = stop_cnt_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they align with state_q.
    ser_en_d = (state_d == START) || (state_d == DATA);
    busy_d   = (state_d != IDLE);

    // Line mux is registered from the current state: TX_OUT lags by one cycle.
    case (mux_sel(state_q))
      MUX_START: tx_out_d = 1'b0;
      MUX_SER:   tx_out_d = ser_data;
`ifdef UART_TX_PARITY_EN
      MUX_PAR:   tx_out_d = par_bit_q;
`endif
      default:   tx_out_d = 1'b1;
    endcase

`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    if (accept) begin
      par_en_d  = PAR_EN;
      par_bit_d = par_calc;
    end
`endif
  end

  // Frame FSM with its registered outputs; async reset aborts any frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      stop_cnt_q <= 2'd0;
      ser_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      tx_out_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      state_q    <= state_d;
      stop_cnt_q <= stop_cnt_d;
      ser_en_q   <= ser_en_d;
      busy_q     <= busy_d;
      tx_out_q   <= tx_out_d;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
`endif
    end
  end

  assign ser_en = ser_en_q;
  assign busy   = busy_q;
  assign TX_OUT = tx_out_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl. Two instances: STOP_BITS = 1 (a) and
// STOP_BITS = 2 (b), each paired with a small behavioural serializer.
// Expected line and busy waveforms are hand-written strings, one character
// per clock cycle after the DATA_VALID cycle.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] p_data = 8'h00;
  logic       dv_a = 1'b0;
  logic       dv_b = 1'b0;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;

  logic sdata_a, sdone_a, sen_a, tx_a, busy_a;
  logic sdata_b, sdone_b, sen_b, tx_b, busy_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(1)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (p_data),
    .DATA_VALID (dv_a),
`ifdef UART_TX_PARITY_EN
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
`endif
    .ser_data   (sdata_a),
    .ser_done   (sdone_a),
    .ser_en     (sen_a),
    .TX_OUT     (tx_a),
    .busy       (busy_a)
  );

  uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(2)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (p_data),
    .DATA_VALID (dv_b),
`ifdef UART_TX_PARITY_EN
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
`endif
    .ser_data   (sdata_b),
    .ser_done   (sdone_b),
    .ser_en     (sen_b),
    .TX_OUT     (tx_b),
    .busy       (busy_b)
  );

  // Behavioural serializers: reload while disabled, shift LSB-first when enabled.
  logic [7:0] sh_a, sh_b;
  logic [3:0] cnt_a, cnt_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_a <= 8'h00; cnt_a <= 4'd0; sdata_a <= 1'b0;
    end else if (!sen_a) begin
      sh_a <= p_data; cnt_a <= 4'd0;
    end else begin
      sdata_a <= sh_a[0]; sh_a <= sh_a >> 1;
      if (cnt_a != 4'd15) cnt_a <= cnt_a + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_b <= 8'h00; cnt_b <= 4'd0; sdata_b <= 1'b0;
    end else if (!sen_b) begin
      sh_b <= p_data; cnt_b <= 4'd0;
    end else begin
      sdata_b <= sh_b[0]; sh_b <= sh_b >> 1;
      if (cnt_b != 4'd15) cnt_b <= cnt_b + 4'd1;
    end
  end

  assign sdone_a = (cnt_a == 4'd8);
  assign sdone_b = (cnt_b == 4'd8);

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", tag, obs, exp);
    end
  endtask

  // Pulse DATA_VALID with d1 on one instance, optionally a second pulse with
  // d2 at cycle dv2_k, then compare per-cycle TX_OUT/busy/ser_en to strings.
  task automatic run_seq(input string tag, input bit sel, input logic [7:0] d1,
                         input int dv2_k, input logic [7:0] d2,
                         input string tx_s, input string busy_s, input string sen_s);
    @(posedge clk); #1;
    p_data = d1;
    if (sel) dv_b = 1'b1; else dv_a = 1'b1;
    for (int k = 1; k <= tx_s.len(); k++) begin
      @(posedge clk); #1;
      if (k == dv2_k) begin
        p_data = d2;
        if (sel) dv_b = 1'b1; else dv_a = 1'b1;
      end else begin
        dv_a = 1'b0; dv_b = 1'b0;
      end
      @(negedge clk);
      check($sformatf("%s tx k%0d", tag, k), sel ? tx_b : tx_a, tx_s[k-1] == 8'h31);
      check($sformatf("%s busy k%0d", tag, k), sel ? busy_b : busy_a, busy_s[k-1] == 8'h31);
      if (k <= sen_s.len())
        check($sformatf("%s ser_en k%0d", tag, k), sel ? sen_b : sen_a, sen_s[k-1] == 8'h31);
    end
    dv_a = 1'b0; dv_b = 1'b0;
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst tx_a", tx_a, 1'b1);
    check("rst busy_a", busy_a, 1'b0);
    check("rst ser_en_a", sen_a, 1'b0);
    check("rst tx_b", tx_b, 1'b1);
    check("rst busy_b", busy_b, 1'b0);
    rst = 1'b1;

    // Single 0xA5 frame, no parity.
    run_seq("a5", 1'b0, 8'hA5, 0, 8'h00,
            "101010010111", "111111111100", "111111111000");

`ifdef UART_TX_PARITY_EN
    // 0x07 with even parity (bit 1) then odd parity (bit 0): 11-cycle frames.
    par_en = 1'b1; par_typ = 1'b0;
    run_seq("par_even", 1'b0, 8'h07, 0, 8'h00, "1011100000111", "1111111111100", "");
    par_typ = 1'b1;
    run_seq("par_odd", 1'b0, 8'h07, 0, 8'h00, "1011100000011", "1111111111100", "");
    par_en = 1'b0; par_typ = 1'b0;
`endif

    // Back-to-back: 0x55 then 0x0F requested on the last stop cycle.
    run_seq("b2b", 1'b0, 8'h55, 10, 8'h0F,
            "1010101010101111000011", "1111111111111111111100", "");

    // Request mid-DATA is ignored; 0x3C completes and no second frame follows.
    run_seq("ignore", 1'b0, 8'h3C, 5, 8'hFF,
            "10001111001111", "11111111110000", "");

    // Async reset during DATA cycle 4 of a 0x00 frame.
    @(posedge clk); #1;
    p_data = 8'h00; dv_a = 1'b1;
    @(posedge clk); #1;
    dv_a = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("pre_rst busy", busy_a, 1'b1);
    check("pre_rst tx", tx_a, 1'b0);
    rst = 1'b0;
    #1;
    check("mid_rst tx", tx_a, 1'b1);
    check("mid_rst busy", busy_a, 1'b0);
    check("mid_rst ser_en", sen_a, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("post_rst idle busy", busy_a, 1'b0);
    run_seq("post_rst", 1'b0, 8'hA5, 0, 8'h00,
            "101010010111", "111111111100", "111111111000");

    // Two stop bits, payload 0x00: line low 9 cycles, busy 11 cycles.
    run_seq("stop2", 1'b1, 8'h00, 0, 8'h00,
            "1000000000111", "1111111111100", "1111111110000");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
